// File: rtl/song_sel_ctl.sv
// Song-selection controller: tracks the selected player, sequences its reset window and muxes its audio/pixels.
// Optional auto-advance on end of song when SONG_SEL_AUTO_ADVANCE_EN is defined.
module song_sel_ctl #(
   parameter int unsigned      NUM_SONGS  = 4,
   parameter int unsigned      PIX_W      = 16,
   parameter int unsigned      SW_RST_CYC = 4,
   parameter logic [PIX_W-1:0] IDLE_PIX   = PIX_W'(16'hF800)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         stop,
   input  logic                         next_song,
   input  logic                         pre_song,
   input  logic [NUM_SONGS*PIX_W-1:0]   pixel_data,
   input  logic [NUM_SONGS-1:0]         buzzer,
   input  logic [NUM_SONGS-1:0]         play_done,
   output logic [NUM_SONGS-1:0]         play_en,
   output logic [NUM_SONGS-1:0]         song_rst,
   output logic [PIX_W-1:0]             o_pixel_data,
   output logic [3:0]                   o_hex_data,
   output logic [$clog2(NUM_SONGS)-1:0] sel,
   output logic                         start_stop,
   output logic                         frq
);

   localparam int unsigned SEL_W    = $clog2(NUM_SONGS);
   localparam int unsigned CNT_W    = 8;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SW_RST_CYC - 1);
   localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(NUM_SONGS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SWITCH = 2'd1,
      RUN    = 2'd2
   } state_t;

   state_t               state, state_nx;
   logic [SEL_W-1:0]     sel_nx;
   logic [CNT_W-1:0]     cnt, cnt_nx;
   logic                 next_song_q, pre_song_q;
   logic                 nx, pv, adv, go_next, go_prev;
   logic                 start_stop_nx, frq_nx;
   logic [NUM_SONGS-1:0] play_en_nx, song_rst_nx;

   assign nx = next_song & ~next_song_q;
   assign pv = pre_song & ~pre_song_q;

`ifdef SONG_SEL_AUTO_ADVANCE_EN
   // End of the playing song behaves like a next-song press.
   assign adv = (state == RUN) & start_stop & play_done[sel];
`else
   logic unused_play_done;
   assign unused_play_done = ^play_done;
   assign adv = 1'b0;
`endif

   assign go_next = nx | adv;
   assign go_prev = pv;

   // State register, selection, window counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sel         <= '0;
         cnt         <= '0;
         next_song_q <= 1'b0;
         pre_song_q  <= 1'b0;
         start_stop  <= 1'b1;
         frq         <= 1'b0;
         play_en     <= '0;
         song_rst    <= '1;
      end else begin
         state       <= state_nx;
         sel         <= sel_nx;
         cnt         <= cnt_nx;
         next_song_q <= next_song;
         pre_song_q  <= pre_song;
         start_stop  <= start_stop_nx;
         frq         <= frq_nx;
         play_en     <= play_en_nx;
         song_rst    <= song_rst_nx;
      end
   end

   // Next-state: a lone next/prev event re-enters SWITCH with a fresh window
   always_comb begin
      state_nx = state;
      sel_nx   = sel;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            state_nx = SWITCH;
            sel_nx   = '0;
            cnt_nx   = CNT_LOAD;
         end
         SWITCH, RUN: begin
            if (go_next && !go_prev) begin
               sel_nx   = (sel == SEL_MAX) ? '0 : sel + SEL_W'(1);
               state_nx = SWITCH;
               cnt_nx   = CNT_LOAD;
            end else if (go_prev && !go_next) begin
               sel_nx   = (sel == '0) ? SEL_MAX : sel - SEL_W'(1);
               state_nx = SWITCH;
               cnt_nx   = CNT_LOAD;
            end else if (state == SWITCH) begin
               if (cnt == '0) state_nx = RUN;
               else           cnt_nx   = cnt - CNT_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Outputs: player controls follow the next state so they line up with it
   always_comb begin
      play_en_nx  = '0;
      song_rst_nx = '1;
      if (state_nx == RUN) begin
         play_en_nx[sel_nx]  = 1'b1;
         song_rst_nx[sel_nx] = 1'b0;
      end
      if (stop)       start_stop_nx = 1'b0;
      else if (start) start_stop_nx = 1'b1;
      else            start_stop_nx = start_stop;
      frq_nx = ((state == RUN) && start_stop) ? ~buzzer[sel] : 1'b0;
      if (state == IDLE) begin
         o_pixel_data = IDLE_PIX;
         o_hex_data   = 4'd0;
      end else begin
         o_pixel_data = pixel_data[sel*PIX_W +: PIX_W];
         o_hex_data   = 4'(sel) + 4'd1;
      end
   end

endmodule

// File: doc/song_sel_ctl.md
# song_sel_ctl

Parametrised song-selection controller for the DE1 music player: N-channel successor of the 4-song selector FSM. Tracks the selected song, drives per-song player enables and resets, muxes the selected player's buzzer to the audio output and its pixel stream to the display. Adds a timed reset window on every song change, button edge detection, and optional auto-advance on end of song. Sits between the debounced key inputs and the per-song `music_top*` players.

## Interface
- `NUM_SONGS`, default 4: number of player channels; legal range 2..15.
- `PIX_W`, default 16: pixel width in bits (RGB565 at 16).
- `SW_RST_CYC`, default 4: cycles of player reset held on each song change; legal range 1..255.
- `IDLE_PIX`, default 16'hF800: pixel value driven in IDLE (red).
- `clk` in 1: system clock.
- `rst` in 1: reset; synchronous, active-high.
- `start` in 1: resume request, level, already synchronous and debounced.
- `stop` in 1: pause request, level.
- `next_song` in 1: select next song, level; the block edge-detects it.
- `pre_song` in 1: select previous song, level; the block edge-detects it.
- `pixel_data` in NUM_SONGS*PIX_W: per-song pixel data; song k occupies bits [k*PIX_W +: PIX_W].
- `buzzer` in NUM_SONGS: per-song buzzer outputs.
- `play_done` in NUM_SONGS: per-song one-cycle end-of-song pulses.
- `play_en` out NUM_SONGS: one-hot player enable.
- `song_rst` out NUM_SONGS: active-high per-player reset.
- `o_pixel_data` out PIX_W: selected pixel data.
- `o_hex_data` out 4: displayed song number (sel+1).
- `sel` out clog2(NUM_SONGS): current song index.
- `start_stop` out 1: 1 = playing, 0 = paused (LED).
- `frq` out 1: audio/buzzer output.

## Operation
- **Reset values:**
  - `sel` = 0, `start_stop` = 1, `frq` = 0.
  - `play_en` = 0, `song_rst` = all 1s.
  - `o_hex_data` = 0, `o_pixel_data` = IDLE_PIX.
  - Button edge registers = 0. State = IDLE.
- **Button edges:** `nx` = `next_song` & ~`next_song_q`; `pv` = `pre_song` & ~`pre_song_q`. Holding a button produces exactly one event.
- **States:**
  - **IDLE:** lasts one cycle, then goes to SWITCH with `sel` = 0.
  - **SWITCH:**
    - `song_rst[sel]` = 1 and `play_en` = 0.
    - An 8-bit counter loads SW_RST_CYC-1 on entry and decrements each cycle.
    - At 0 the FSM goes to RUN.
  - **RUN:**
    - `play_en[sel]` = 1, `song_rst[sel]` = 0.
    - All other channels have `song_rst` = 1 and `play_en` = 0.
- **Selection (SWITCH or RUN):**
  - `nx` alone: `sel` = (sel==NUM_SONGS-1) ? 0 : sel+1, then enter SWITCH with the counter reloaded.
  - `pv` alone: `sel` = (sel==0) ? NUM_SONGS-1 : sel-1, then enter SWITCH with the counter reloaded.
  - `nx` and `pv` in the same cycle: both are ignored.
  - An event during SWITCH restarts the reset window on the new index.
- **Start/stop:**
  - `stop` clears `start_stop`; `start` sets it.
  - Both high in the same cycle: `stop` wins.
  - `start_stop` is independent of state and is kept across song changes.
- **Audio:** `frq` is registered. `frq` <= ~`buzzer[sel]` when state is RUN and `start_stop` = 1; otherwise `frq` <= 0.
- **Display:**
  - SWITCH/RUN: `o_pixel_data` = slice `sel`, `o_hex_data` = sel+1.
  - IDLE: `o_pixel_data` = IDLE_PIX, `o_hex_data` = 0.
  - Both are combinational from the registered state and `sel`.
- **Pause:** `play_en[sel]` stays 1 while paused. Players use their own `start_stop` copy, so pause does not reset the song.

## Timing
- Button level high at edge t with low at t-1:
  - `sel` and state update at edge t.
  - `song_rst[new]` is high for cycles t+1 .. t+SW_RST_CYC.
  - `play_en[new]` goes high from t+SW_RST_CYC+1.
- `frq` lags `buzzer[sel]` by one cycle.
- `start_stop` updates one cycle after `start`/`stop` is sampled.
- `rst` asserted mid-operation returns every output to its reset value at the next edge, regardless of state.

## Configuration
- **`SONG_SEL_AUTO_ADVANCE_EN` defined:**
  - In RUN with `start_stop` = 1, `play_done[sel]` acts as `nx`: the index wraps and the FSM enters SWITCH.
  - Same cycle as `pv`: treated as simultaneous and ignored.
  - Same cycle as `nx`: one advance only.
- **Undefined:** `play_done` is ignored entirely and `sel` changes only on buttons.

## Test plan
- **Reset and bring-up:** `rst` 3 cycles, NUM_SONGS=4, SW_RST_CYC=4 -> IDLE 1 cycle; `song_rst[0]` high 4 cycles; then `play_en` = 4'b0001, `o_hex_data` = 1, `o_pixel_data` = slice 0.
- **Wrap both ways:** `next_song` edge ×4 -> `sel` 1,2,3,0. `pre_song` edge from 0 -> `sel` = 3, `o_hex_data` = 4.
- **Held and simultaneous buttons:** `next_song` held 20 cycles -> exactly one advance. `next_song` and `pre_song` rising together -> `sel` unchanged, no SWITCH.
- **Pause:** `stop` -> `start_stop` 0 and `frq` 0 next cycle while `buzzer` toggles. `start` and `stop` together -> stays 0. `start` -> `frq` follows ~`buzzer[sel]` with 1-cycle lag.
- **Re-press during SWITCH:** `next_song` edge during SWITCH at count 2 -> `sel` +1 again; full 4-cycle `song_rst` window restarts on the new song.
- **Auto-advance** (macro defined): `play_done[2]` pulse in RUN at `sel` = 2 -> `sel` = 3 via SWITCH. Macro undefined: same pulse -> no change.
